// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial link: the bit-order encoding used on both
// ends of the link, and the receiver state type.
package serial_link_pkg;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/serial_word_receiver_if.sv
// Serial-in / parallel-out bundle of the word receiver. The slave modport is the
// receiver's view and the master modport is the view of whatever drives it.
interface serial_word_receiver_if #(
    parameter int WIDTH = 4
) ();

    logic             s_in;
    logic             s_valid;
    logic             frame_start;
    logic             dir;
    logic [WIDTH-1:0] p_out;
    logic             p_valid;
    logic             p_ready;
    logic             busy;
    logic             overrun;
    logic             clr_ovr;

    modport slave (
        input  s_in, s_valid, frame_start, dir, p_ready, clr_ovr,
        output p_out, p_valid, busy, overrun
    );

    modport master (
        output s_in, s_valid, frame_start, dir, p_ready, clr_ovr,
        input  p_out, p_valid, busy, overrun
    );

endinterface

// File: rtl/serial_word_receiver_word_hold_buf.sv
// One-entry valid/ready holding register for completed words. A word that
// arrives while the entry is full and not being drained is dropped and flagged.
module word_hold_buf #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rest_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_word,
    input  logic             p_ready,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] p_out,
    output logic             p_valid,
    output logic             overrun
);

    logic can_load;
    logic drop;

    // A drain in the same cycle frees the entry, so back-to-back words never bubble.
    assign can_load = !p_valid || p_ready;
    assign drop     = load_valid && !can_load;

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            p_out   <= '0;
            p_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (load_valid && can_load) begin
                p_out   <= load_word;
                p_valid <= 1'b1;
            end else if (p_valid && p_ready) begin
                p_valid <= 1'b0;
            end

            // A new drop outranks a clear arriving in the same cycle.
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_word_receiver.sv
// Deserialiser: collects WIDTH accepted bits into a word (LSB- or MSB-first,
// chosen at the first bit) and hands it to a one-entry output buffer.
module serial_word_receiver
    import serial_link_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   rest_n,
    serial_word_receiver_if.slave  bus
);

    rx_state_t        state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] shift_reg;
    logic             dir_q_reg;

    logic             start;
    logic             eff_dir;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] rshift;
    logic [WIDTH-1:0] lshift;
    logic [WIDTH-1:0] shift_next;
    logic [CNT_W-1:0] cnt_next;
    logic             word_done;

    // frame_start restarts a partial word as bit 0, exactly as a fresh word from IDLE.
    assign start   = (state_reg == RX_IDLE) || bus.frame_start;
    assign eff_dir = start ? bus.dir : dir_q_reg;
    assign base    = start ? '0 : shift_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == WIDTH - 1) begin : g_rtop
                assign rshift[gi] = bus.s_in;
            end else begin : g_rmid
                assign rshift[gi] = base[gi+1];
            end
            if (gi == 0) begin : g_lbot
                assign lshift[gi] = bus.s_in;
            end else begin : g_lmid
                assign lshift[gi] = base[gi-1];
            end
        end
    endgenerate

    assign shift_next = (eff_dir == DIR_MSB_FIRST) ? lshift : rshift;
    assign cnt_next   = start ? CNT_W'(1) : cnt_reg + CNT_W'(1);
    assign word_done  = bus.s_valid && (cnt_next == CNT_W'(WIDTH));

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            state_reg <= RX_IDLE;
            cnt_reg   <= '0;
            shift_reg <= '0;
            dir_q_reg <= DIR_LSB_FIRST;
        end else if (bus.s_valid) begin
            dir_q_reg <= eff_dir;
            shift_reg <= shift_next;
            if (word_done) begin
                state_reg <= RX_IDLE;
                cnt_reg   <= '0;
            end else begin
                state_reg <= RX_SHIFT;
                cnt_reg   <= cnt_next;
            end
        end
    end

    assign bus.busy = (state_reg == RX_SHIFT);

    word_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold_buf (
        .clk        (clk),
        .rest_n     (rest_n),
        .load_valid (word_done),
        .load_word  (shift_next),
        .p_ready    (bus.p_ready),
        .clr_ovr    (bus.clr_ovr),
        .p_out      (bus.p_out),
        .p_valid    (bus.p_valid),
        .overrun    (bus.overrun)
    );

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver (WIDTH=4); expected words are
// hand-computed from the bit sequences sent.
module tb_serial_word_receiver;

    localparam int WIDTH = 4;

    logic clk;
    logic rest_n;
    int   total;
    int   bad;

    serial_word_receiver_if #(.WIDTH(WIDTH)) bus ();

    serial_word_receiver #(
        .WIDTH (WIDTH)
    ) dut (
        .clk    (clk),
        .rest_n (rest_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("chk %s: got %0h ok", tag, obs);
        end
    endtask

    // Present one bit for one clock edge; returns 1 time unit after the edge.
    task automatic send_bit(input logic b, input logic fs, input logic d);
        bus.s_in        = b;
        bus.s_valid     = 1'b1;
        bus.frame_start = fs;
        bus.dir         = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.s_valid     = 1'b0;
        bus.frame_start = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bits(input logic [3:0] bits, input logic d);
        // bits[3] is sent first
        for (int k = 3; k >= 0; k--) send_bit(bits[k], 1'b0, d);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rest_n          = 1'b0;
        bus.s_in        = 1'b0;
        bus.s_valid     = 1'b0;
        bus.frame_start = 1'b0;
        bus.dir         = 1'b0;
        bus.p_ready     = 1'b1;
        bus.clr_ovr     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_p_out",   32'(bus.p_out), 32'h0);
        check_val("rst_p_valid", 32'(bus.p_valid), 32'h0);
        check_val("rst_busy",    32'(bus.busy), 32'h0);
        check_val("rst_overrun", 32'(bus.overrun), 32'h0);
        rest_n = 1'b1;
        idle(1);

        // LSB-first 1,0,1,1 -> D
        send_bit(1'b1, 1'b0, 1'b0);
        check_val("lsb_busy_b1", 32'(bus.busy), 32'h1);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        check_val("lsb_nvalid_b3", 32'(bus.p_valid), 32'h0);
        send_bit(1'b1, 1'b0, 1'b0);
        check_val("lsb_p_out",   32'(bus.p_out), 32'hD);
        check_val("lsb_p_valid", 32'(bus.p_valid), 32'h1);
        check_val("lsb_busy_end", 32'(bus.busy), 32'h0);
        idle(1);
        check_val("lsb_drained", 32'(bus.p_valid), 32'h0);
        check_val("lsb_retain",  32'(bus.p_out), 32'hD);

        // MSB-first 1,0,1,1 -> B
        send_bits(4'b1011, 1'b1);
        check_val("msb_p_out", 32'(bus.p_out), 32'hB);
        idle(1);
        // dir flipped after first bit is ignored
        send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        check_val("msb_flip_p_out", 32'(bus.p_out), 32'hB);
        idle(1);

        // gaps: 1,1, three idle cycles, 0,0 -> 3
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        idle(3);
        check_val("gap_busy", 32'(bus.busy), 32'h1);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        check_val("gap_p_out",   32'(bus.p_out), 32'h3);
        check_val("gap_p_valid", 32'(bus.p_valid), 32'h1);
        idle(1);

        // abort: 1,1,1 then frame_start with 0,1,0,1 -> A
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
        check_val("abort_nvalid", 32'(bus.p_valid), 32'h0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        check_val("abort_p_out",   32'(bus.p_out), 32'hA);
        check_val("abort_overrun", 32'(bus.overrun), 32'h0);
        idle(1);

        // overrun: 5 (1,0,1,0) then 9 (1,0,0,1) with p_ready low
        bus.p_ready = 1'b0;
        send_bits(4'b1010, 1'b0);
        check_val("ovr_first", 32'(bus.p_out), 32'h5);
        send_bits(4'b1001, 1'b0);
        check_val("ovr_p_out",   32'(bus.p_out), 32'h5);
        check_val("ovr_set",     32'(bus.overrun), 32'h1);
        check_val("ovr_p_valid", 32'(bus.p_valid), 32'h1);
        idle(2);
        check_val("ovr_sticky", 32'(bus.overrun), 32'h1);
        bus.clr_ovr = 1'b1;
        idle(1);
        bus.clr_ovr = 1'b0;
        check_val("ovr_cleared", 32'(bus.overrun), 32'h0);
        bus.p_ready = 1'b1;
        idle(1);
        check_val("ovr_drained", 32'(bus.p_valid), 32'h0);
        check_val("ovr_retain",  32'(bus.p_out), 32'h5);

        // back-to-back 1, 2, 3 with continuous s_valid
        send_bits(4'b1000, 1'b0);
        check_val("b2b_w1", 32'(bus.p_out), 32'h1);
        check_val("b2b_v1", 32'(bus.p_valid), 32'h1);
        send_bit(1'b0, 1'b0, 1'b0);
        check_val("b2b_gap1", 32'(bus.p_valid), 32'h0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        check_val("b2b_w2", 32'(bus.p_out), 32'h2);
        check_val("b2b_v2", 32'(bus.p_valid), 32'h1);
        send_bit(1'b1, 1'b0, 1'b0);
        check_val("b2b_gap2", 32'(bus.p_valid), 32'h0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        check_val("b2b_w3", 32'(bus.p_out), 32'h3);
        check_val("b2b_v3", 32'(bus.p_valid), 32'h1);
        check_val("b2b_overrun", 32'(bus.overrun), 32'h0);
        idle(1);

        // simultaneous drain and completion: 6 held, then 7 completes as p_ready rises
        bus.p_ready = 1'b0;
        send_bits(4'b0110, 1'b0);
        check_val("sim_first", 32'(bus.p_out), 32'h6);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        bus.p_ready = 1'b1;
        send_bit(1'b0, 1'b0, 1'b0);
        check_val("sim_p_out",   32'(bus.p_out), 32'h7);
        check_val("sim_p_valid", 32'(bus.p_valid), 32'h1);
        check_val("sim_overrun", 32'(bus.overrun), 32'h0);
        // clr_ovr coincident with a drop: set wins
        bus.p_ready = 1'b0;
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        bus.clr_ovr = 1'b1;
        send_bit(1'b1, 1'b0, 1'b0);
        bus.clr_ovr = 1'b0;
        check_val("setwins_overrun", 32'(bus.overrun), 32'h1);
        check_val("setwins_p_out",   32'(bus.p_out), 32'h7);

        // asynchronous reset mid-word with a buffered word and overrun pending
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        check_val("pre_rst_busy", 32'(bus.busy), 32'h1);
        #2;
        rest_n = 1'b0;
        #1;
        check_val("arst_p_out",   32'(bus.p_out), 32'h0);
        check_val("arst_p_valid", 32'(bus.p_valid), 32'h0);
        check_val("arst_busy",    32'(bus.busy), 32'h0);
        check_val("arst_overrun", 32'(bus.overrun), 32'h0);
        bus.s_valid = 1'b0;
        @(negedge clk);
        rest_n = 1'b1;
        @(posedge clk);
        #1;
        bus.p_ready = 1'b1;
        send_bits(4'b1011, 1'b0);
        check_val("post_rst_p_out",   32'(bus.p_out), 32'hD);
        check_val("post_rst_p_valid", 32'(bus.p_valid), 32'h1);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
- Receiving end of the serial link driven by the team's universal shift register.
- Deserialises a bit stream into WIDTH-bit parallel words.
- Supports LSB-first or MSB-first ordering and frame-start alignment.
- Presents each completed word through a one-entry valid/ready output buffer with sticky overrun detection; sits between the serial pin-side logic and the parallel datapath.

Parameters:
- WIDTH, 4, bits per word; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), width of the bit counter; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rest_n  input  1  asynchronous active-low reset
- s_in  input  1  serial data bit
- s_valid  input  1  s_in holds a valid bit this cycle
- frame_start  input  1  qualified by s_valid; this bit is bit 0 of a new word
- dir  input  1  0 = LSB-first, 1 = MSB-first; sampled on the first bit of each word
- p_out  output  WIDTH  assembled word, stable while p_valid=1
- p_valid  output  1  p_out holds an unconsumed word
- p_ready  input  1  consumer accepts p_out when p_valid && p_ready
- busy  output  1  partial word in progress (state SHIFT)
- overrun  output  1  sticky: a completed word was dropped
- clr_ovr  input  1  synchronous clear of overrun

Behaviour:
- Reset is asynchronous and active-low on rest_n. While rest_n=0:
  - p_out=0, p_valid=0, busy=0, overrun=0.
  - Shift register=0, counter=0, state=IDLE.
- Release is synchronous to the next clk edge.
- A bit is accepted only when s_valid=1; cycles with s_valid=0 hold all shift state.
- FSM states: IDLE and SHIFT.
  - IDLE: on an accepted bit, latch dir into dir_q, store the bit, counter=1, go to SHIFT.
  - SHIFT: on each accepted bit, counter increments.
  - When an accepted bit brings the counter to WIDTH, the word completes, counter returns to 0 and the FSM goes to IDLE.
- frame_start=1 with s_valid=1 in SHIFT aborts the partial word silently and restarts as bit 0, re-sampling dir. In IDLE it has no extra effect.
- Bit placement for bit index k (0-based arrival order):
  - dir_q=0: bit k goes to word[k], so the first bit is the LSB.
  - dir_q=1: bit k goes to word[WIDTH-1-k], so the first bit is the MSB.
  - Implemented as a right shift (dir_q=0, new bit enters at the MSB) or left shift (dir_q=1, new bit enters at the LSB); equivalent results.
- Changes to dir mid-word are ignored.
- Completion latency: the word appears on p_out with p_valid=1 on the cycle after the edge that accepted the last bit.
- Output buffer (one entry):
  - Load on completion if p_valid=0, or if p_valid && p_ready in the same cycle. In the second case p_valid stays 1 with the new word (back-to-back, no bubble).
  - If completion occurs while p_valid=1 and p_ready=0: the new word is dropped, p_out is unchanged and overrun is set next cycle. Shift logic still returns to IDLE.
  - Consumption with no completion clears p_valid next cycle; p_out retains its last value.
- Overrun:
  - Stays set until clr_ovr=1 or reset.
  - If clr_ovr and a new overrun event coincide, the set wins.
- busy=1 exactly when state=SHIFT.
- Reset mid-word discards the partial word and any buffered word.

Decomposition:
- Shared package serial_link_pkg holds:
  - DIR_LSB_FIRST=1'b0 and DIR_MSB_FIRST=1'b1 (same encoding the transmitter side uses).
  - rx_state_t enum {RX_IDLE, RX_SHIFT}.
- One natural sub-module: word_hold_buf, the one-entry valid/ready output register with the overrun flag.
- Deserialiser FSM and counter stay in the top module.

Test Plan:
1. Reset/basic: rest_n=0 mid-stream (asserted asynchronously between edges) -> all outputs 0 immediately. After release, send dir=0 bits 1,0,1,1 with p_ready=1 -> p_out=4'hD, p_valid=1 one cycle after the 4th bit, busy=1 during bits 2-4.
2. MSB-first: dir=1, bits 1,0,1,1 -> p_out=4'hB; flip dir after bit 1 -> still 4'hB.
3. Gaps and frame abort:
   - Bits 1,1 then s_valid=0 for 3 cycles, then 0,0 -> p_out=4'h3.
   - Separately, bits 1,1,1 then frame_start with bits 0,1,0,1 (dir=0) -> p_out=4'hA, no overrun.
4. Overrun: p_ready=0, send 4'h5 then 4'h9 (dir=0) -> p_out stays 4'h5, overrun=1 the cycle after the 8th bit. Pulse clr_ovr -> overrun=0. Assert p_ready -> p_valid=0 next cycle.
5. Back-to-back: p_ready tied 1, continuous s_valid, 3 words 4'h1, 4'h2, 4'h3 -> p_valid high one cycle per word at 4-cycle spacing, overrun=0.
6. Simultaneous: complete a word on the same cycle as p_ready drains the buffer -> p_valid stays 1 with the new word, no overrun. Repeat with clr_ovr coincident with an overrun event -> overrun=1.
